xalu_nibble_sequencer: RTL and testbench

//  Multi-cycle controller that runs one combinational 4-bit ALU slice NIBBLES times to do
//  4*NIBBLES-bit ALU operations. Carries chain between nibbles through internal registers.

---
 rtl/xalu_pkg.sv | 26 ++
 rtl/xalu_slice4.sv | 41 ++++
 rtl/xalu_nibble_sequencer.sv | 110 +++++++++++
 tb/tb_xalu_nibble_sequencer.sv | 184 ++++++++++++++++++
 4 files changed

// File: rtl/xalu_pkg.sv
// Shared definitions for the nibble-serial ALU: function codes, sequencer states
// and the latched operation descriptor.
package xalu_pkg;
  localparam int NIBBLE_W = 4;

  localparam logic [2:0] FN_ADD   = 3'd0;
  localparam logic [2:0] FN_AND   = 3'd1;
  localparam logic [2:0] FN_OR    = 3'd2;
  localparam logic [2:0] FN_XOR   = 3'd3;
  localparam logic [2:0] FN_PASSA = 3'd4;
  localparam logic [2:0] FN_PASSB = 3'd5;
  localparam logic [2:0] FN_SHR   = 3'd6;
  localparam logic [2:0] FN_SHL   = 3'd7;

  typedef enum logic [1:0] {ST_IDLE, ST_RUN, ST_DONE} state_e;

  typedef struct packed {
    logic [2:0] func;
    logic       com;
  } op_t;

  // Functions whose final carry register is reported on cout.
  function automatic logic carry_func(input logic [2:0] f);
    return (f == FN_ADD) || (f == FN_SHR) || (f == FN_SHL);
  endfunction
endpackage

// File: rtl/xalu_slice4.sv
// Combinational 4-bit ALU slice; carries enter/leave on both sides so the
// sequencer can chain shifts in either direction.
module xalu_slice4
  import xalu_pkg::*;
(
  input  logic [NIBBLE_W-1:0] a4,
  input  logic [NIBBLE_W-1:0] b4,
  input  logic [2:0]          func,
  input  logic                com,
  input  logic                ci_left,
  input  logic                ci_right,
  output logic [NIBBLE_W-1:0] d4,
  output logic                co_left,
  output logic                co_right,
  output logic                equ
);
  logic [NIBBLE_W:0]   sum;
  logic [NIBBLE_W-1:0] raw;

  always_comb begin
    sum      = {1'b0, a4} + {1'b0, b4} + {{NIBBLE_W{1'b0}}, ci_right};
    raw      = '0;
    co_left  = 1'b0;
    co_right = 1'b0;
    case (func)
      FN_ADD:   begin raw = sum[NIBBLE_W-1:0]; co_left = sum[NIBBLE_W]; end
      FN_AND:   raw = a4 & b4;
      FN_OR:    raw = a4 | b4;
      FN_XOR:   raw = a4 ^ b4;
      FN_PASSA: raw = a4;
      FN_PASSB: raw = b4;
      FN_SHR:   begin raw = {ci_left, a4[NIBBLE_W-1:1]}; co_right = a4[0]; end
      FN_SHL:   begin raw = {a4[NIBBLE_W-2:0], ci_right}; co_left = a4[NIBBLE_W-1]; end
      default:  raw = '0;
    endcase
  end

  // Inversion is applied after the carry is taken so com never disturbs the chain.
  assign d4  = com ? ~raw : raw;
  assign equ = (a4 == b4);
endmodule

// File: rtl/xalu_nibble_sequencer.sv
// Runs one xalu_slice4 NIBBLES times to build a 4*NIBBLES-bit ALU op, with a
// start/busy/done handshake and wide status flags.
module xalu_nibble_sequencer
  import xalu_pkg::*;
#(
  parameter int NIBBLES = 4
) (
  input  logic                        clk,
  input  logic                        rst_n,
  input  logic                        start,
  input  logic                        hold,
  input  logic [2:0]                  func,
  input  logic                        com,
  input  logic                        cin,
  input  logic [NIBBLE_W*NIBBLES-1:0] a,
  input  logic [NIBBLE_W*NIBBLES-1:0] b,
  output logic                        busy,
  output logic                        done,
  output logic [NIBBLE_W*NIBBLES-1:0] result,
  output logic                        cout,
  output logic                        zero,
  output logic                        neg_zero,
  output logic                        equ
);
  localparam int CW = (NIBBLES > 1) ? $clog2(NIBBLES) : 1;
  localparam logic [CW-1:0] LAST = CW'(NIBBLES - 1);

  state_e state, state_nxt;
  op_t    op_q;
  logic [NIBBLES-1:0][NIBBLE_W-1:0] a_q, b_q, res_q;
  logic [CW-1:0] cnt, idx;
  logic carry_q, equ_acc, flags_vld;
  logic accept, step, shr;
  logic [NIBBLE_W-1:0] s_d4;
  logic s_co_left, s_co_right, s_equ;

  assign accept = (state == ST_IDLE) && start;
  assign step   = (state == ST_RUN) && !hold;
  assign shr    = (op_q.func == FN_SHR);
  // Right shifts walk MSB nibble first so the carry moves toward bit 0.
  assign idx    = shr ? LAST - cnt : cnt;

  xalu_slice4 u_slice (
    .a4       (a_q[idx]),
    .b4       (b_q[idx]),
    .func     (op_q.func),
    .com      (op_q.com),
    .ci_left  (shr ? carry_q : 1'b0),
    .ci_right (shr ? 1'b0 : carry_q),
    .d4       (s_d4),
    .co_left  (s_co_left),
    .co_right (s_co_right),
    .equ      (s_equ)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= ST_IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      ST_IDLE: if (start) state_nxt = ST_RUN;
      ST_RUN:  if (!hold && cnt == LAST) state_nxt = ST_DONE;
      ST_DONE: state_nxt = ST_IDLE;
      default: state_nxt = ST_IDLE;
    endcase
  end

  always_comb begin
    busy = (state == ST_RUN) || (state == ST_DONE);
    done = (state == ST_DONE);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      op_q      <= '0;
      a_q       <= '0;
      b_q       <= '0;
      res_q     <= '0;
      cnt       <= '0;
      carry_q   <= 1'b0;
      equ_acc   <= 1'b0;
      flags_vld <= 1'b0;
    end else if (accept) begin
      op_q      <= '{func: func, com: com};
      a_q       <= a;
      b_q       <= b;
      res_q     <= '0;
      cnt       <= '0;
      carry_q   <= cin;
      equ_acc   <= 1'b1;
      flags_vld <= 1'b0;
    end else if (step) begin
      res_q[idx] <= s_d4;
      carry_q    <= shr ? s_co_right : s_co_left;
      equ_acc    <= equ_acc & s_equ;
      cnt        <= cnt + CW'(1);
      if (cnt == LAST) flags_vld <= 1'b1;
    end
  end

  // Flags stay quiet until the last nibble lands, then hold with the result.
  assign result   = res_q;
  assign cout     = flags_vld & carry_func(op_q.func) & carry_q;
  assign zero     = flags_vld & (res_q == '0);
  assign neg_zero = flags_vld & (res_q == '1);
  assign equ      = flags_vld & equ_acc;
endmodule

// File: tb/tb_xalu_nibble_sequencer.sv
// Table-driven and randomized checks of the nibble sequencer against a
// full-width arithmetic reference model.
module tb_xalu_nibble_sequencer;
  localparam int NIB = 4;
  localparam int W   = 4 * NIB;

  typedef struct {
    logic [W-1:0] r;
    logic c, z, n, e;
  } exp_t;

  typedef struct {
    logic [2:0]   f;
    logic         cm, ci;
    logic [W-1:0] a, b;
    exp_t         ex;
  } vec_t;

  logic clk = 1'b0, rst_n = 1'b0;
  logic start = 1'b0, hold = 1'b0, com = 1'b0, cin = 1'b0;
  logic [2:0] func = 3'd0;
  logic [W-1:0] a = '0, b = '0;
  logic busy, done, cout, zero, neg_zero, equ;
  logic [W-1:0] result;

  int errors = 0;
  int checks = 0;

  xalu_nibble_sequencer #(.NIBBLES(NIB)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .hold(hold), .func(func),
    .com(com), .cin(cin), .a(a), .b(b), .busy(busy), .done(done),
    .result(result), .cout(cout), .zero(zero), .neg_zero(neg_zero), .equ(equ)
  );

  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  // Whole-word reference: ALU op on full operands, then optional inversion.
  function automatic exp_t model(input logic [2:0] f, input logic cm, input logic ci,
                                 input logic [W-1:0] aa, input logic [W-1:0] bb);
    exp_t e;
    logic [W:0] s;
    logic [W-1:0] r;
    e.c = 1'b0;
    r = '0;
    case (f)
      3'd0: begin s = {1'b0, aa} + {1'b0, bb} + {{W{1'b0}}, ci}; r = s[W-1:0]; e.c = s[W]; end
      3'd1: r = aa & bb;
      3'd2: r = aa | bb;
      3'd3: r = aa ^ bb;
      3'd4: r = aa;
      3'd5: r = bb;
      3'd6: begin r = {ci, aa[W-1:1]}; e.c = aa[0]; end
      default: begin r = {aa[W-2:0], ci}; e.c = aa[W-1]; end
    endcase
    if (cm) r = ~r;
    e.r = r;
    e.z = (r == '0);
    e.n = (r == '1);
    e.e = (aa == bb);
    return e;
  endfunction

  task automatic run_op(input string tag, input logic [2:0] f, input logic cm, input logic ci,
                        input logic [W-1:0] aa, input logic [W-1:0] bb,
                        input int hold_after, input int hold_len,
                        input bit pulse_mid, input bit start_done, input exp_t ex);
    int  k;
    bit  got;
    @(negedge clk);
    func = f; com = cm; cin = ci; a = aa; b = bb; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    chk({tag, ".busy_at_accept"}, busy, 1);
    chk({tag, ".done_at_accept"}, done, 0);
    k = 0;
    got = 0;
    while (!got && k < 40) begin
      hold = (hold_len > 0) && (k >= hold_after) && (k < hold_after + hold_len);
      if (pulse_mid && k == 1) begin
        start = 1'b1; a = ~aa; b = $urandom; func = 3'($urandom_range(0, 7)); cin = ~ci;
      end
      if (pulse_mid && k == 2) start = 1'b0;
      @(posedge clk); #1;
      k++;
      if (done) got = 1;
    end
    hold = 1'b0;
    start = 1'b0;
    if (!got) begin
      errors++;
      checks++;
      $display("FAIL %s.timeout: done not seen within %0d cycles", tag, k);
      return;
    end
    chk({tag, ".latency"}, k, NIB + hold_len);
    chk({tag, ".result"}, result, ex.r);
    chk({tag, ".cout"}, cout, ex.c);
    chk({tag, ".zero"}, zero, ex.z);
    chk({tag, ".neg_zero"}, neg_zero, ex.n);
    chk({tag, ".equ"}, equ, ex.e);
    if (start_done) start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    chk({tag, ".done_pulse_end"}, done, 0);
    chk({tag, ".busy_end"}, busy, 0);
    chk({tag, ".result_held"}, result, ex.r);
  endtask

  vec_t vecs[12];

  initial begin
    vecs[0]  = '{3'd0, 1'b0, 1'b0, 16'h1234, 16'h0FFF, '{16'h2233, 1'b0, 1'b0, 1'b0, 1'b0}};
    vecs[1]  = '{3'd0, 1'b0, 1'b0, 16'hFFFF, 16'h0001, '{16'h0000, 1'b1, 1'b1, 1'b0, 1'b0}};
    vecs[2]  = '{3'd7, 1'b0, 1'b1, 16'h8001, 16'h0000, '{16'h0003, 1'b1, 1'b0, 1'b0, 1'b0}};
    vecs[3]  = '{3'd6, 1'b0, 1'b0, 16'h8001, 16'h0000, '{16'h4000, 1'b1, 1'b0, 1'b0, 1'b0}};
    vecs[4]  = '{3'd3, 1'b1, 1'b0, 16'h5A5A, 16'h5A5A, '{16'hFFFF, 1'b0, 1'b0, 1'b1, 1'b1}};
    vecs[5]  = '{3'd1, 1'b0, 1'b0, 16'hF0F0, 16'h3C3C, '{16'h3030, 1'b0, 1'b0, 1'b0, 1'b0}};
    vecs[6]  = '{3'd2, 1'b1, 1'b0, 16'h1200, 16'h0034, '{16'hEDCB, 1'b0, 1'b0, 1'b0, 1'b0}};
    vecs[7]  = '{3'd5, 1'b0, 1'b1, 16'h0000, 16'hABCD, '{16'hABCD, 1'b0, 1'b0, 1'b0, 1'b0}};
    vecs[8]  = '{3'd4, 1'b1, 1'b1, 16'hFFFF, 16'hFFFF, '{16'h0000, 1'b0, 1'b1, 1'b0, 1'b1}};
    vecs[9]  = '{3'd0, 1'b1, 1'b0, 16'h8000, 16'h8000, '{16'hFFFF, 1'b1, 1'b0, 1'b1, 1'b1}};
    vecs[10] = '{3'd6, 1'b0, 1'b1, 16'h0001, 16'h0000, '{16'h8000, 1'b1, 1'b0, 1'b0, 1'b0}};
    vecs[11] = '{3'd0, 1'b0, 1'b1, 16'h00FF, 16'h0000, '{16'h0100, 1'b0, 1'b0, 1'b0, 1'b0}};

    #2;
    chk("reset.busy", busy, 0);
    chk("reset.done", done, 0);
    chk("reset.result", result, 0);
    chk("reset.flags", {cout, zero, neg_zero, equ}, 4'b0000);
    #10 rst_n = 1'b1;

    for (int i = 0; i < 12; i++)
      run_op($sformatf("vec%0d", i), vecs[i].f, vecs[i].cm, vecs[i].ci,
             vecs[i].a, vecs[i].b, 0, 0, 1'b0, 1'b0, vecs[i].ex);

    // Two hold cycles mid-RUN plus a stray start with garbage operands.
    run_op("hold_pulse", vecs[0].f, 1'b0, 1'b0, vecs[0].a, vecs[0].b, 1, 2, 1'b1, 1'b0, vecs[0].ex);
    // start raised during the DONE cycle must not launch a new op.
    run_op("start_in_done", vecs[4].f, 1'b1, 1'b0, vecs[4].a, vecs[4].b, 0, 0, 1'b0, 1'b1, vecs[4].ex);

    // Reset in the second RUN cycle.
    @(negedge clk);
    func = 3'd0; com = 1'b0; cin = 1'b0; a = 16'h1234; b = 16'h0FFF; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    @(posedge clk); #1;
    rst_n = 1'b0;
    #1;
    chk("midreset.busy", busy, 0);
    chk("midreset.done", done, 0);
    chk("midreset.result", result, 0);
    chk("midreset.flags", {cout, zero, neg_zero, equ}, 4'b0000);
    @(negedge clk);
    rst_n = 1'b1;
    run_op("after_reset", 3'd0, 1'b0, 1'b0, 16'h1234, 16'h0FFF, 0, 0, 1'b0, 1'b0, vecs[0].ex);

    for (int i = 0; i < 40; i++) begin
      logic [2:0] f;
      logic cm, ci;
      logic [W-1:0] ra, rb;
      int ha, hl;
      f  = 3'($urandom_range(0, 7));
      cm = 1'($urandom);
      ci = 1'($urandom);
      ra = W'($urandom);
      rb = ($urandom_range(0, 3) == 0) ? ra : W'($urandom);
      ha = $urandom_range(0, 3);
      hl = $urandom_range(0, 2);
      run_op($sformatf("rnd%0d", i), f, cm, ci, ra, rb, ha, hl,
             1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), model(f, cm, ci, ra, rb));
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
